// File: rtl/number_builder_pkg.sv
// Shared constants for the G-code number builder.
// Digit/byte widths and the largest legal decimal digit.
package number_builder_pkg;

  localparam int DIGIT_BITS = 4;
  localparam int BYTE_BITS  = 8;

  localparam logic [DIGIT_BITS-1:0] MAX_DIGIT = 4'd9;

  typedef logic [DIGIT_BITS-1:0] digit_t;

endpackage

// File: rtl/number_builder_mul10_add.sv
// Combinational acc*10 + digit, truncated to NUM_BITS.
// Ports: acc (in), digit (in), result (out).
module number_builder_mul10_add
  import number_builder_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic [NUM_BITS-1:0]   acc,
  input  logic [DIGIT_BITS-1:0] digit,
  output logic [NUM_BITS-1:0]   result
);

  localparam int WIDE = NUM_BITS + 4;

  logic [WIDE-1:0] acc_w;
  logic [WIDE-1:0] dig_w;
  logic [WIDE-1:0] wide;

  assign acc_w = {4'b0, acc};
  assign dig_w = {{(WIDE-DIGIT_BITS){1'b0}}, digit};

  // x*10 = x*8 + x*2; the extra 4 bits hold the carry-out, then dropped
  assign wide   = (acc_w << 3) + (acc_w << 1) + dig_w;
  assign result = NUM_BITS'(wide);

endmodule

// File: rtl/number_builder.sv
// Decimal digit accumulator with combinational sign output.
// Ports: clk, reset, clk_en, zero, is_negative, digit, advance, num.
module number_builder
  import number_builder_pkg::*;
#(
  parameter int NUM_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  zero,
  input  logic                  is_negative,
  input  logic [DIGIT_BITS-1:0] digit,
  input  logic                  advance,
  output logic [NUM_BITS-1:0]   num
);

  logic [NUM_BITS-1:0] acc;
  logic [NUM_BITS-1:0] acc_next;
  logic                digit_ok;

  number_builder_mul10_add #(
    .NUM_BITS (NUM_BITS)
  ) u_mul10_add (
    .acc    (acc),
    .digit  (digit),
    .result (acc_next)
  );

  assign digit_ok = (digit <= MAX_DIGIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clk_en) begin
      if (zero) begin
        acc <= '0;
      end else if (advance && digit_ok) begin
        acc <= acc_next;
      end
    end
  end

  // The MSB-only value maps to itself under negation
  assign num = is_negative ? (~acc + NUM_BITS'(1)) : acc;

endmodule

// File: tb/tb_number_builder.sv
// Scoreboard bench for number_builder (NUM_BITS = 8).
// Driver queues expected num; monitor compares at negedge.
module tb_number_builder;

  localparam int NB = 8;

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          zero;
  logic          is_negative;
  logic [3:0]    digit;
  logic          advance;
  logic [NB-1:0] num;

  number_builder #(
    .NUM_BITS (NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .zero        (zero),
    .is_negative (is_negative),
    .digit       (digit),
    .advance     (advance),
    .num         (num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int    exp;
    string tag;
  } item_t;

  item_t q[$];

  int tests;
  int fails;

  // Reference: magnitude as a plain integer in 0..255
  int acc_m;
  bit known;

  function automatic int signed_view(input int a, input bit neg);
    return neg ? ((256 - a) % 256) : a;
  endfunction

  task automatic step(input bit r, input bit en, input bit z,
                      input bit neg, input int d, input bit adv,
                      input string tag);
    @(posedge clk);
    #1;
    reset       = r;
    clk_en      = en;
    zero        = z;
    is_negative = neg;
    digit       = 4'(d);
    advance     = adv;
    if (known) q.push_back('{exp: signed_view(acc_m, neg), tag: tag});
    if (r) begin
      acc_m = 0;
      known = 1'b1;
    end else if (en) begin
      if (z) begin
        acc_m = 0;
        known = 1'b1;
      end else if (adv && d <= 9) begin
        acc_m = (acc_m * 10 + d) % 256;
      end
    end
  endtask

  task automatic idle(input string tag, input bit neg = 1'b0);
    step(1'b0, 1'b1, 1'b0, neg, 0, 1'b0, tag);
  endtask

  task automatic adv_digit(input int d, input string tag);
    step(1'b0, 1'b1, 1'b0, 1'b0, d, 1'b1, tag);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      tests++;
      if (int'(num) != it.exp) begin
        fails++;
        $display("FAIL %s: num=%0d (0x%02h) expected %0d (0x%02h)",
                 it.tag, num, num, it.exp, it.exp[7:0]);
      end
    end
  end

  initial begin
    tests       = 0;
    fails       = 0;
    acc_m       = 0;
    known       = 1'b0;
    reset       = 1'b1;
    clk_en      = 1'b1;
    zero        = 1'b0;
    is_negative = 1'b0;
    digit       = 4'd0;
    advance     = 1'b0;

    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, "reset");
    step(1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, "reset_neg");
    step(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, "no_adv");
    step(1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, "no_adv2");

    adv_digit(3, "pre3");
    adv_digit(7, "show3");
    idle("show37");
    idle("hold37");

    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, "pre_zero");
    adv_digit(1, "zeroed");
    idle("show1");
    adv_digit(0, "hold1");
    idle("show10");
    adv_digit(3, "hold10");
    idle("show103");
    idle("neg103", 1'b1);
    idle("pos103");

    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, "pre_zero2");
    adv_digit(3, "z2");
    adv_digit(0, "show3b");
    adv_digit(5, "show30");
    idle("wrap305");

    step(1'b0, 1'b1, 1'b1, 1'b0, 7, 1'b1, "zero_adv");
    idle("zero_wins");

    adv_digit(4, "pre4");
    adv_digit(12, "show4");
    idle("digit12");
    step(1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1, "en_off");
    idle("en_off_hold");

    adv_digit(2, "pre42");
    step(1'b1, 1'b1, 1'b0, 1'b0, 9, 1'b1, "show42");
    idle("mid_reset");

    adv_digit(1, "m1");
    adv_digit(2, "m12");
    adv_digit(8, "m128a");
    idle("show128");
    idle("neg128", 1'b1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 11) == 0,
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 6,
           "random");
    end

    idle("tail");
    idle("tail");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
